gshare_pht_spec: RTL and testbench



---
 rtl/gshare_pht_spec.sv | 148 ++++++++++++++
 tb/tb_gshare_pht_spec.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht_spec.sv
// gshare branch predictor with an internal PHT of 2-bit saturating counters,
// a speculatively updated global history register, and an in-order FIFO of
// outstanding predictions used for training and history repair.
module gshare_pht_spec #(
   parameter int         IDX_W    = 4,
   parameter int         HIST_W   = 4,
   parameter int         DEPTH    = 4,
   parameter logic [1:0] CTR_INIT = 2'b01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_valid,
   input  logic [IDX_W-1:0]  pred_pc,
   output logic              pred_ready,
   output logic              pred_out_valid,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              mispredict,
   output logic              res_err,
   output logic [HIST_W-1:0] hist_out
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Saturating 2-bit counter step: up on taken, down on not-taken.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
      logic [1:0] nxt;
      if (up) begin
         nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return nxt;
   endfunction

   // Shift one outcome into the low end of a history value; the cast keeps
   // the low HIST_W bits, which also covers a one-bit history.
   function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h, input logic b);
      return HIST_W'({h, b});
   endfunction

   // Pointer advance with wrap at DEPTH-1 (works for non-power-of-two depths).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   logic [1:0]        pht_r [ENTRIES];
   logic [HIST_W-1:0] ghr_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [IDX_W-1:0]  fifo_idx_r  [DEPTH];
   logic [HIST_W-1:0] fifo_hist_r [DEPTH];
   logic              fifo_pred_r [DEPTH];

   logic [IDX_W-1:0]  idx_s;
   logic              pred_bit_s;
   logic              accept_s;
   logic              empty_s;
   logic              pop_s;
   logic              mis_s;
   logic              push_s;
   logic [IDX_W-1:0]  head_idx_s;
   logic [HIST_W-1:0] head_hist_s;
   logic              head_pred_s;
   logic [HIST_W-1:0] ghr_nxt_s;
   logic [CNT_W-1:0]  cnt_nxt_s;

   // Index/lookup, resolve decode, and next-state for history and count.
   always_comb begin
      pred_ready  = (cnt_r < CNT_W'(DEPTH));
      hist_out    = ghr_r;
      idx_s       = pred_pc ^ IDX_W'(ghr_r);
      pred_bit_s  = pht_r[idx_s][1];
      accept_s    = pred_valid && pred_ready;
      empty_s     = (cnt_r == CNT_W'(0));
      head_idx_s  = fifo_idx_r[rd_ptr_r];
      head_hist_s = fifo_hist_r[rd_ptr_r];
      head_pred_s = fifo_pred_r[rd_ptr_r];
      pop_s       = res_valid && !empty_s;
      mis_s       = pop_s && (res_taken != head_pred_s);
      // A mispredict flush drops any same-cycle request; fetch reissues it.
      push_s      = accept_s && !mis_s;

      if (mis_s) begin
         ghr_nxt_s = hist_shift(head_hist_s, res_taken);
      end else if (push_s) begin
         ghr_nxt_s = hist_shift(ghr_r, pred_bit_s);
      end else begin
         ghr_nxt_s = ghr_r;
      end

      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
         2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // State and registered outputs; reset wins over any same-cycle request.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht_r[i] <= CTR_INIT;
         end
         ghr_r          <= '0;
         cnt_r          <= '0;
         rd_ptr_r       <= '0;
         wr_ptr_r       <= '0;
         pred_out_valid <= 1'b0;
         pred_taken     <= 1'b0;
         mispredict     <= 1'b0;
         res_err        <= 1'b0;
      end else begin
         // Training write; the lookup above already used the old value.
         if (pop_s) begin
            pht_r[head_idx_s] <= ctr_step(pht_r[head_idx_s], res_taken);
         end
         if (push_s) begin
            fifo_idx_r[wr_ptr_r]  <= idx_s;
            fifo_hist_r[wr_ptr_r] <= ghr_r;
            fifo_pred_r[wr_ptr_r] <= pred_bit_s;
            pred_taken            <= pred_bit_s;
         end
         if (mis_s) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
         end else begin
            if (pop_s) begin
               rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_s) begin
               wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            cnt_r <= cnt_nxt_s;
         end
         ghr_r          <= ghr_nxt_s;
         pred_out_valid <= push_s;
         mispredict     <= mis_s;
         res_err        <= res_valid && empty_s;
      end
   end

endmodule

// File: tb/tb_gshare_pht_spec.sv
// Self-checking bench for gshare_pht_spec (default parameters): a
// queue-based reference model checked every cycle, plus directed
// vectors with hand-computed literal expectations.
module tb_gshare_pht_spec;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pred_valid = 1'b0;
   logic [3:0] pred_pc = 4'd0;
   logic       res_valid = 1'b0;
   logic       res_taken = 1'b0;
   logic       pred_ready, pred_out_valid, pred_taken, mispredict, res_err;
   logic [3:0] hist_out;

   gshare_pht_spec dut (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
      .pred_ready(pred_ready), .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
      .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict),
      .res_err(res_err), .hist_out(hist_out)
   );

   always #5 clk = ~clk;

   typedef struct {int idx; int ghr; bit pred;} ent_t;

   int   checks = 0;
   int   errors = 0;
   int   m_pht [16];
   int   m_ghr = 0;
   ent_t mq [$];
   bit   e_pov = 0, e_pt = 0, e_mis = 0, e_err = 0;
   bit   model_on = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask

   // Reference model: one call per rising edge with that edge's inputs.
   task automatic model_step(input bit rs, input bit pv, input int pc, input bit rv, input bit rt);
      int   idx;
      bit   pred, acc, mis;
      ent_t e;
      if (rs) begin
         for (int i = 0; i < 16; i++) m_pht[i] = 1;
         m_ghr = 0; mq.delete();
         e_pov = 0; e_pt = 0; e_mis = 0; e_err = 0;
      end else begin
         acc  = pv && (mq.size() < 4);
         idx  = (pc ^ m_ghr) & 15;
         pred = (m_pht[idx] >= 2);
         mis  = 0;
         e_err = 0;
         if (rv) begin
            if (mq.size() == 0) begin
               e_err = 1;
            end else begin
               e = mq.pop_front();
               if (rt) m_pht[e.idx] = (m_pht[e.idx] == 3) ? 3 : m_pht[e.idx] + 1;
               else    m_pht[e.idx] = (m_pht[e.idx] == 0) ? 0 : m_pht[e.idx] - 1;
               if (rt != e.pred) begin
                  mis = 1;
                  mq.delete();
                  m_ghr = ((e.ghr << 1) | int'(rt)) & 15;
               end
            end
         end
         e_mis = mis;
         if (acc && !mis) begin
            mq.push_back('{idx, m_ghr, pred});
            m_ghr = ((m_ghr << 1) | int'(pred)) & 15;
            e_pov = 1;
            e_pt  = pred;
         end else begin
            e_pov = 0;
         end
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (model_on) begin
         chk("pred_out_valid", pred_out_valid, e_pov);
         chk("pred_taken", pred_taken, e_pt);
         chk("mispredict", mispredict, e_mis);
         chk("res_err", res_err, e_err);
         chk("hist_out", hist_out, m_ghr);
         chk("pred_ready", pred_ready, (mq.size() < 4) ? 1 : 0);
      end
   end

   task automatic step(input bit rs, input bit pv, input int pc, input bit rv, input bit rt);
      rst = rs; pred_valid = pv; pred_pc = pc[3:0]; res_valid = rv; res_taken = rt;
      @(posedge clk);
      model_step(rs, pv, pc, rv, rt);
      @(negedge clk);
      #1;
   endtask

   bit rsv  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   bit pexp [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   int hexp;

   initial begin
      model_on = 1;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("rst_pov", pred_out_valid, 1'b0);
      chk("rst_hist", hist_out, 4'h0);
      chk("rst_ready", pred_ready, 1'b1);

      // Basic predict and repair.
      step(0, 1, 3, 0, 0);
      chk("basic_pov", pred_out_valid, 1'b1);
      chk("basic_pt", pred_taken, 1'b0);
      chk("basic_hist", hist_out, 4'h0);
      step(0, 0, 0, 1, 1);
      chk("basic_mis", mispredict, 1'b1);
      chk("basic_repair", hist_out, 4'h1);
      step(0, 1, 3, 0, 0);             // idx 2, counter 01
      chk("basic_pt2", pred_taken, 1'b0);
      step(0, 1, 1, 0, 0);             // idx 3, counter 10 after training
      chk("pht3_trained", pred_taken, 1'b1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      chk("correct_nomis", mispredict, 1'b0);

      // Saturation at idx 5, both ends.
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 5 ^ m_ghr, 0, 0);
         chk("sat_pred", pred_taken, pexp[i]);
         step(0, 0, 0, 1, rsv[i]);
      end

      // Full FIFO.
      for (int i = 0; i < 4; i++) step(0, 1, i, 0, 0);
      chk("full_ready", pred_ready, 1'b0);
      step(0, 1, 9, 0, 0);
      chk("full_drop", pred_out_valid, 1'b0);
      step(0, 0, 0, 1, mq[0].pred);
      chk("full_recover", pred_ready, 1'b1);

      // Flush with 3 outstanding.
      hexp = ((mq[0].ghr << 1) | int'(!mq[0].pred)) & 15;
      step(0, 0, 0, 1, !mq[0].pred);
      chk("flush_mis", mispredict, 1'b1);
      chk("flush_hist", hist_out, hexp);
      step(0, 0, 0, 1, 0);
      chk("flush_err", res_err, 1'b1);

      // Same-cycle predict with mispredicting resolve.
      step(0, 1, 3, 0, 0);
      step(0, 1, 7, 1, !mq[0].pred);
      chk("sc_mis_pov", pred_out_valid, 1'b0);
      chk("sc_mis", mispredict, 1'b1);
      step(0, 0, 0, 1, 1);
      chk("sc_mis_empty", res_err, 1'b1);

      // Same-cycle predict with correct resolve on the same index.
      step(0, 1, 6, 0, 0);
      step(0, 1, mq[0].idx ^ m_ghr, 1, mq[0].pred);
      chk("sc_ok_pov", pred_out_valid, 1'b1);
      step(0, 0, 0, 1, mq[0].pred);
      step(0, 0, 0, 1, 0);
      chk("sc_ok_count", res_err, 1'b1);

      // Reset mid-operation.
      step(0, 1, 1, 0, 0);
      step(0, 1, 2, 0, 0);
      step(1, 1, 2, 1, 1);
      chk("mid_pov", pred_out_valid, 1'b0);
      chk("mid_pt", pred_taken, 1'b0);
      chk("mid_mis", mispredict, 1'b0);
      chk("mid_err", res_err, 1'b0);
      chk("mid_hist", hist_out, 4'h0);
      chk("mid_ready", pred_ready, 1'b1);
      step(0, 1, 3, 0, 0);
      chk("mid_pht_init", pred_taken, 1'b0);

      // Mixed traffic against the model.
      for (int i = 0; i < 80; i++) begin
         step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      model_on = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
